ram_stream_loader: RTL and testbench
====================================

# ram_stream_loader

Sequencing controller that sits directly upstream of the 16x8 single-port asynchronous-read RAM and owns its write and address ports. It fills consecutive RAM locations from a valid/ready byte stream and, on command, dumps a range back out as a registered valid/ready stream. It is the only master of the RAM's `we`/`addr`/`din` and sole consumer of its `dout`.

## Interface
- `DATA_W`, 8, data width; matches RAM word width
- `ADDR_W`, 4, address width; RAM depth = 2**ADDR_W = 16

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start_fill`  in  1  one-cycle command: begin fill at address 0
- `start_dump`  in  1  one-cycle command: begin dump from address 0
- `len`  in  ADDR_W+1  number of words to fill or dump; sampled with the start command; 0 or >16 treated as 16
- `in_valid`  in  1  input byte valid
- `in_data`  in  DATA_W  input byte
- `in_ready`  out  1  loader accepts input byte
- `out_valid`  out  1  output byte valid
- `out_data`  out  DATA_W  output byte, registered
- `out_ready`  in  1  downstream accepts output byte
- `ram_we`  out  1  to RAM `we`
- `ram_addr`  out  ADDR_W  to RAM `addr`
- `ram_din`  out  DATA_W  to RAM `din`
- `ram_dout`  in  DATA_W  from RAM `dout` (combinational read)
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse when a fill or dump completes

## Operation
- States: IDLE, FILL, DUMP_RD, DUMP_OUT.
- Internal: address counter `cnt` (ADDR_W+1 bits), latched length `len_q` (1..16).
- IDLE: `in_ready`=0, `out_valid`=0, `ram_we`=0, `ram_addr`=0. `start_fill` -> FILL; `start_dump` -> DUMP_RD. Both asserted in the same cycle: fill wins, dump command dropped. Both latch `len_q` and clear `cnt`.
- FILL: `in_ready`=1; `ram_addr`=`cnt`; `ram_din`=`in_data`; `ram_we`=`in_valid` (combinational). Each accepted byte increments `cnt`. Accept with `cnt`=`len_q`-1: pulse `done` next cycle, return to IDLE.
- DUMP_RD: `ram_addr`=`cnt`; on the clock edge `out_data`<=`ram_dout`, `out_valid`<=1, go to DUMP_OUT.
- DUMP_OUT: `out_valid`=1; `out_data` and `ram_addr` held stable until `out_ready`. On `out_valid && out_ready`: if `cnt`=`len_q`-1, `out_valid`<=0, pulse `done`, go to IDLE; otherwise `cnt`++ and go to DUMP_RD.
- `start_fill` and `start_dump` are ignored outside IDLE.
- `ram_we` never asserts outside FILL.
- Address never wraps within an operation. `cnt` is bounded by `len_q`≤16.

## Timing
- Reset (`rst_n`=0, async): state IDLE, `cnt`=0, `len_q`=16. Outputs: `in_ready`=0, `out_valid`=0, `out_data`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0 (forced while not FILL), `busy`=0, `done`=0.
- Reset mid-operation aborts immediately. RAM contents already written are retained. No resume.
- Fill: start in cycle N; first byte is acceptable in cycle N+1. Throughput is 1 byte/cycle. The write lands on the clock edge of the handshake.
- Dump: start in cycle N; DUMP_RD in N+1; first `out_valid` in N+2. Each word costs 2 cycles minimum (DUMP_RD + DUMP_OUT), so peak throughput is 1 word per 2 cycles.
- `done` is high for exactly the one cycle after the final handshake. `busy` is already 0 in that cycle, and a new start is accepted in that cycle.
- `out_data` must not change while `out_valid`=1 and `out_ready`=0.

## Test plan
- Reset then full fill: `start_fill` with `len`=0, stream bytes 0x10..0x1F with `in_valid` held high. Required: 16 writes to addr 0..15, `done` one cycle after the 16th handshake, `busy` low afterwards.
- Dump after fill: `start_dump` with `len`=16, `out_ready`=1. Required: `out_data` sequence 0x10..0x1F, first `out_valid` 2 cycles after start, 2 cycles per word, single `done` pulse.
- Partial fill with gaps: `len`=3, `in_valid` toggling 1,0,1,0,1 with data A5, --, 5A, --, 3C. Required: addr0=A5, addr1=5A, addr2=3C; `ram_we` only on valid cycles; `done` after the 3rd accept; addr3 unchanged.
- Backpressure: dump with `len`=2, `out_ready` low for 5 cycles on word 0. Required: `out_valid` stays 1 and `out_data` stays stable for all 5 cycles; word 1 follows 2 cycles after release.
- Command conflicts: `start_fill` and `start_dump` in the same cycle. Required: FILL entered. `start_dump` during FILL is ignored, with no effect on `cnt` or state.
- Async reset mid-fill: assert `rst_n`=0 after 5 of 16 bytes. Required: all outputs reach reset values without waiting for a clock edge; addr0..4 retain their data; a new fill restarts at addr 0.

Source files
------------

// File: rtl/ram_stream_loader.sv
// Fill/dump sequencer for a 16x8 asynchronous-read RAM: writes a valid/ready byte
// stream into consecutive locations and replays a range as a registered stream.
module ram_stream_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_fill,
    input  logic              start_dump,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2 ** ADDR_W);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FILL     = 2'd1,
        DUMP_RD  = 2'd2,
        DUMP_OUT = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [CNT_W-1:0]  len_q_r, len_q_s;
    logic [DATA_W-1:0] out_data_r, out_data_s;
    logic              done_r, done_s;
    logic              is_last_s;

    // A length of zero or beyond the RAM depth means "whole RAM".
    function automatic logic [CNT_W-1:0] norm_len(input logic [CNT_W-1:0] l);
        if ((l == {CNT_W{1'b0}}) || (l > DEPTH)) begin
            return DEPTH;
        end else begin
            return l;
        end
    endfunction

    assign is_last_s = (cnt_r == (len_q_r - CNT_W'(1)));

    // Next-state, counter, length latch and output-data selection.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        len_q_s    = len_q_r;
        out_data_s = out_data_r;
        done_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_fill) begin
                    state_s = FILL;
                    len_q_s = norm_len(len);
                    cnt_s   = {CNT_W{1'b0}};
                end else if (start_dump) begin
                    state_s = DUMP_RD;
                    len_q_s = norm_len(len);
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            FILL: begin
                if (in_valid) begin
                    if (is_last_s) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_s = FILL;
                end
            end
            DUMP_RD: begin
                out_data_s = ram_dout;
                state_s    = DUMP_OUT;
            end
            DUMP_OUT: begin
                if (out_ready) begin
                    if (is_last_s) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        cnt_s   = cnt_r + CNT_W'(1);
                        state_s = DUMP_RD;
                    end
                end else begin
                    state_s = DUMP_OUT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            len_q_r    <= DEPTH;
            out_data_r <= {DATA_W{1'b0}};
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            len_q_r    <= len_q_s;
            out_data_r <= out_data_s;
            done_r     <= done_s;
        end
    end

    // RAM port and stream handshakes decode straight from the state register.
    assign in_ready  = (state_r == FILL);
    assign ram_we    = (state_r == FILL) && in_valid;
    assign ram_din   = (state_r == FILL) ? in_data : {DATA_W{1'b0}};
    assign ram_addr  = (state_r == IDLE) ? {ADDR_W{1'b0}} : cnt_r[ADDR_W-1:0];
    assign out_valid = (state_r == DUMP_OUT);
    assign out_data  = out_data_r;
    assign busy      = (state_r != IDLE);
    assign done      = done_r;

endmodule

// File: tb/tb_ram_stream_loader.sv
// Directed bench for ram_stream_loader with a behavioural 16x8 async-read RAM.
module tb_ram_stream_loader;

    logic       clk;
    logic       rst_n;
    logic       start_fill;
    logic       start_dump;
    logic [4:0] len;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
    logic       busy;
    logic       done;

    logic [7:0]  mem [16];
    logic [31:0] got;
    logic [31:0] exp;
    int          total;
    int          bad;

    ram_stream_loader #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_fill(start_fill), .start_dump(start_dump),
        .len(len), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
    end
    assign ram_dout = mem[ram_addr];

    task automatic test_reset();
        rst_n = 1'b0; start_fill = 1'b0; start_dump = 1'b0; len = 5'd0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        #3;
        got = {8'h0, in_ready, out_valid, out_data, ram_we, ram_addr, ram_din, busy, done};
        exp = {8'h0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0};
        total++;
        if (got !== exp) begin bad++; $display("FAIL reset_outputs got=%h exp=%h", got, exp); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_fill();
        start_fill = 1'b1; len = 5'd0;
        @(negedge clk); start_fill = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h10 + i);
            #1;
            got = {16'h0, in_ready, ram_we, ram_addr, ram_din, busy, done};
            exp = {16'h0, 1'b1, 1'b1, 4'(i), 8'(8'h10 + i), 1'b1, 1'b0};
            total++;
            if (got !== exp) begin bad++; $display("FAIL fill_beat%0d got=%h exp=%h", i, got, exp); end
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        got = {28'h0, done, busy, in_ready, ram_we};
        exp = {28'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        total++;
        if (got !== exp) begin bad++; $display("FAIL fill_done got=%h exp=%h", got, exp); end
        @(negedge clk); #1;
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL fill_done_width got=%b exp=0", done); end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (mem[i] !== 8'(8'h10 + i)) begin
                bad++; $display("FAIL fill_mem%0d got=%h exp=%h", i, mem[i], 8'(8'h10 + i));
            end
        end
    endtask

    task automatic test_dump_after_fill();
        @(negedge clk); start_dump = 1'b1; len = 5'd16; out_ready = 1'b1;
        @(negedge clk); start_dump = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            got = {25'h0, out_valid, busy, ram_addr, done};
            exp = {25'h0, 1'b0, 1'b1, 4'(i), 1'b0};
            total++;
            if (got !== exp) begin bad++; $display("FAIL dump_rd%0d got=%h exp=%h", i, got, exp); end
            @(negedge clk); #1;
            got = {18'h0, out_valid, out_data, ram_addr, done};
            exp = {18'h0, 1'b1, 8'(8'h10 + i), 4'(i), 1'b0};
            total++;
            if (got !== exp) begin bad++; $display("FAIL dump_out%0d got=%h exp=%h", i, got, exp); end
            @(negedge clk);
        end
        #1;
        got = {29'h0, done, busy, out_valid};
        exp = {29'h0, 1'b1, 1'b0, 1'b0};
        total++;
        if (got !== exp) begin bad++; $display("FAIL dump_done got=%h exp=%h", got, exp); end
        @(negedge clk); #1;
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL dump_done_width got=%b exp=0", done); end
        out_ready = 1'b0;
    endtask

    task automatic test_partial_fill();
        logic [4:0] vv;
        logic [7:0] dd [5];
        logic [3:0] aa [5];
        logic [7:0] mm [4];
        vv = 5'b10101;
        dd = '{8'hA5, 8'h00, 8'h5A, 8'h00, 8'h3C};
        aa = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2};
        mm = '{8'hA5, 8'h5A, 8'h3C, 8'h13};
        @(negedge clk); start_fill = 1'b1; len = 5'd3;
        @(negedge clk); start_fill = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = vv[4-k]; in_data = dd[k];
            #1;
            got = {26'h0, ram_we, ram_addr, done};
            exp = {26'h0, vv[4-k], aa[k], 1'b0};
            total++;
            if (got !== exp) begin bad++; $display("FAIL gap_beat%0d got=%h exp=%h", k, got, exp); end
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        got = {30'h0, done, busy};
        exp = {30'h0, 1'b1, 1'b0};
        total++;
        if (got !== exp) begin bad++; $display("FAIL gap_done got=%h exp=%h", got, exp); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[i] !== mm[i]) begin bad++; $display("FAIL gap_mem%0d got=%h exp=%h", i, mem[i], mm[i]); end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk); start_dump = 1'b1; len = 5'd2; out_ready = 1'b0;
        @(negedge clk); start_dump = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_rd0 got=%b exp=0", out_valid); end
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            got = {23'h0, out_valid, out_data};
            exp = {23'h0, 1'b1, 8'hA5};
            total++;
            if (got !== exp) begin bad++; $display("FAIL bp_hold%0d got=%h exp=%h", c, got, exp); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        got = {23'h0, out_valid, out_data};
        exp = {23'h0, 1'b1, 8'hA5};
        total++;
        if (got !== exp) begin bad++; $display("FAIL bp_release got=%h exp=%h", got, exp); end
        @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_rd1 got=%b exp=0", out_valid); end
        @(negedge clk); #1;
        got = {19'h0, out_valid, out_data, ram_addr};
        exp = {19'h0, 1'b1, 8'h5A, 4'd1};
        total++;
        if (got !== exp) begin bad++; $display("FAIL bp_word1 got=%h exp=%h", got, exp); end
        @(negedge clk); #1;
        got = {30'h0, done, out_valid};
        exp = {30'h0, 1'b1, 1'b0};
        total++;
        if (got !== exp) begin bad++; $display("FAIL bp_done got=%h exp=%h", got, exp); end
        out_ready = 1'b0;
    endtask

    task automatic test_conflict();
        @(negedge clk); start_fill = 1'b1; start_dump = 1'b1; len = 5'd2;
        @(negedge clk); start_fill = 1'b0; start_dump = 1'b1; len = 5'd1; in_valid = 1'b0;
        #1;
        got = {26'h0, in_ready, out_valid, ram_addr};
        exp = {26'h0, 1'b1, 1'b0, 4'd0};
        total++;
        if (got !== exp) begin bad++; $display("FAIL cmd_fill_wins got=%h exp=%h", got, exp); end
        @(negedge clk); start_dump = 1'b0; in_valid = 1'b1; in_data = 8'h77;
        #1;
        got = {24'h0, in_ready, ram_we, ram_addr, out_valid, done};
        exp = {24'h0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
        total++;
        if (got !== exp) begin bad++; $display("FAIL cmd_ignored0 got=%h exp=%h", got, exp); end
        @(negedge clk); in_data = 8'h78;
        #1;
        got = {24'h0, in_ready, ram_we, ram_addr, out_valid, done};
        exp = {24'h0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0};
        total++;
        if (got !== exp) begin bad++; $display("FAIL cmd_ignored1 got=%h exp=%h", got, exp); end
        @(negedge clk); in_valid = 1'b0;
        #1;
        got = {14'h0, done, busy, mem[0], mem[1]};
        exp = {14'h0, 1'b1, 1'b0, 8'h77, 8'h78};
        total++;
        if (got !== exp) begin bad++; $display("FAIL cmd_result got=%h exp=%h", got, exp); end
    endtask

    task automatic test_async_reset();
        @(negedge clk); start_fill = 1'b1; len = 5'd0;
        @(negedge clk); start_fill = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'(8'hC0 + i);
            @(negedge clk);
        end
        in_valid = 1'b1; in_data = 8'hC5;
        #2; rst_n = 1'b0;
        #1;
        got = {8'h0, in_ready, out_valid, out_data, ram_we, ram_addr, ram_din, busy, done};
        exp = {8'h0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0};
        total++;
        if (got !== exp) begin bad++; $display("FAIL arst_outputs got=%h exp=%h", got, exp); end
        @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (mem[i] !== 8'(8'hC0 + i)) begin
                bad++; $display("FAIL arst_mem%0d got=%h exp=%h", i, mem[i], 8'(8'hC0 + i));
            end
        end
        total++;
        if (mem[5] !== 8'h15) begin bad++; $display("FAIL arst_mem5 got=%h exp=15", mem[5]); end
        @(negedge clk); start_fill = 1'b1; len = 5'd1;
        @(negedge clk); start_fill = 1'b0; in_valid = 1'b1; in_data = 8'hEE;
        #1;
        got = {27'h0, ram_we, ram_addr};
        exp = {27'h0, 1'b1, 4'd0};
        total++;
        if (got !== exp) begin bad++; $display("FAIL arst_restart got=%h exp=%h", got, exp); end
        @(negedge clk); in_valid = 1'b0;
        #1;
        got = {23'h0, done, mem[0]};
        exp = {23'h0, 1'b1, 8'hEE};
        total++;
        if (got !== exp) begin bad++; $display("FAIL arst_refill got=%h exp=%h", got, exp); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_full_fill();
        test_dump_after_fill();
        test_partial_fill();
        test_backpressure();
        test_conflict();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
